// File: rtl/mem_stage_dcache.sv
// mem_stage_dcache: direct-mapped write-through read-allocate MEM-stage data cache with req/ack backing memory.
// Define DCACHE_STATS_EN to add the hitCount/missCount statistics outputs.
module mem_stage_dcache #(
  parameter int INDEX_BITS  = 4,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic        hit,
  output logic [31:0] readData,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
`endif
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS - OFFSET_BITS;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t                  r_state, w_next;
  logic [LINES-1:0]        r_valid;
  logic [TAG_BITS-1:0]     r_tag [LINES];
  logic [31:0]             r_data [LINES*WORDS];
  logic [OFFSET_BITS-1:0]  r_cnt;
  logic [OFFSET_BITS-1:0]  w_off;
  logic [INDEX_BITS-1:0]   w_idx;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_match, w_rd, w_miss, w_last, w_fill_ack, w_unused;
  assign w_off      = address[OFFSET_BITS+1:2];
  assign w_idx      = address[OFFSET_BITS+2 +: INDEX_BITS];
  assign w_tag      = address[31 -: TAG_BITS];
  assign w_match    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_rd       = memRead && !memWrite;
  assign w_miss     = (r_state == IDLE) && w_rd && !w_match;
  assign w_last     = &r_cnt;
  assign w_fill_ack = (r_state == FILL) && memAck;
  assign w_unused   = &{1'b0, address[1:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = memWrite ? WRITE : w_miss ? FILL : IDLE;
      FILL:    w_next = (memAck && w_last) ? DONE : FILL;
      WRITE:   w_next = memAck ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    hit      = (r_state == IDLE) ? !(memWrite || (memRead && !w_match)) : (r_state == DONE);
    readData = r_data[{w_idx, w_off}];
    memReq   = (r_state == FILL) || (r_state == WRITE);
    memWe    = r_state == WRITE;
    memAddr  = (r_state == FILL)  ? {w_tag, w_idx, r_cnt, 2'b00} :
               (r_state == WRITE) ? {address[31:2], 2'b00} : '0;
    memWData = (r_state == WRITE) ? writeData : '0;
  end
  // Valid bits only set once the whole line has arrived, so a reset mid-fill leaves it invalid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_miss) r_cnt <= '0;
      else if (w_fill_ack) r_cnt <= r_cnt + 1'b1;
      if (w_fill_ack && w_last) r_valid[w_idx] <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (w_fill_ack) r_data[{w_idx, r_cnt}] <= memRData;
    if (w_fill_ack && w_last) r_tag[w_idx] <= w_tag;
    if ((r_state == IDLE) && memWrite && w_match) r_data[{w_idx, w_off}] <= writeData;
  end
`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if ((r_state == IDLE) && w_rd && w_match) r_hit_cnt <= r_hit_cnt + 1'b1;
      if (w_miss) r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end
  assign hitCount  = r_hit_cnt;
  assign missCount = r_miss_cnt;
`endif
endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb_mem_stage_dcache: randomized bench for mem_stage_dcache against a line-level cache and word-memory model.
module tb_mem_stage_dcache;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0, writeData = '0, memRData = '0, memAddr, memWData, readData;
  logic        memRead = 1'b0, memWrite = 1'b0, memAck = 1'b0, hit, memReq, memWe;
`ifdef DCACHE_STATS_EN
  logic [31:0] hitCount, missCount;
`endif
  mem_stage_dcache dut (
    .clk(clk), .reset(reset), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite), .hit(hit), .readData(readData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memAck(memAck)
`ifdef DCACHE_STATS_EN
    , .hitCount(hitCount), .missCount(missCount)
`endif
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int lat_mode = 0, lat_sum = 0, wl = -1, e_hit = 0, e_miss = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bk_mem  [logic [31:0]];
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  bit          q_we [$];
  logic [31:0] q_addr [$], q_wd [$];
  bit          p_req = 0, p_ack = 0;
  logic [31:0] p_addr = '0, p_wd = '0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] dflt(input logic [31:0] w);
    return (w * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    logic [31:0] w = {a[31:2], 2'b00};
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction
  function automatic logic [31:0] bk_rd(input logic [31:0] w);
    return bk_mem.exists(w) ? bk_mem[w] : dflt(w);
  endfunction
  // Backing memory: acks each request after lat_mode (or random 0..3) waiting cycles
  initial begin
    forever begin
      @(negedge clk);
      memAck = 1'b0;
      if (memReq && !reset) begin
        if (p_req && !p_ack) begin
          chk("req_addr_stable", memAddr, p_addr);
          chk("req_wdata_stable", memWData, p_wd);
        end
        if (wl < 0) begin
          wl = (lat_mode < 0) ? int'($urandom_range(3, 0)) : lat_mode;
          lat_sum += wl;
        end
        if (wl == 0) begin
          memAck = 1'b1;
          q_we.push_back(memWe);
          q_addr.push_back(memAddr);
          q_wd.push_back(memWData);
          if (memWe) bk_mem[memAddr] = memWData;
          else memRData = bk_rd(memAddr);
          wl = -1;
        end else wl--;
      end else wl = -1;
      p_req = memReq; p_ack = memAck; p_addr = memAddr; p_wd = memWData;
    end
  end
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd);
    int stall, exp_stall, n;
    logic [3:0]  idx = a[7:4];
    logic [23:0] tg = a[31:8];
    bit mhit = m_valid[idx] && (m_tag[idx] == tg);
    @(posedge clk); #1;
    address = a; writeData = wd; memRead = rd; memWrite = wr;
    q_we.delete(); q_addr.delete(); q_wd.delete();
    lat_sum = 0;
    stall = 0;
    while (stall <= 100) begin
      @(negedge clk);
      if (hit) break;
      stall++;
    end
    exp_stall = wr ? 2 + lat_sum : (rd && !mhit) ? 5 + lat_sum : 0;
    chk("stall_cycles", stall, exp_stall);
    n = wr ? 1 : (rd && !mhit) ? 4 : 0;
    chk("txn_count", q_addr.size(), n);
    if (rd && !wr) chk("read_data", readData, ref_rd(a));
    for (int i = 0; i < n && i < q_addr.size(); i++) begin
      chk("txn_we", {31'b0, q_we[i]}, {31'b0, wr});
      chk("txn_addr", q_addr[i], wr ? {a[31:2], 2'b00} : {a[31:4], 4'(i * 4)});
      if (wr) chk("txn_wdata", q_wd[i], wd);
    end
    if (wr) ref_mem[{a[31:2], 2'b00}] = wd;
    else if (rd && !mhit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
      e_miss++;
    end else if (rd) e_hit++;
    @(posedge clk); #1;
    memRead = 1'b0; memWrite = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
      bk_mem[32'h100 + 32'(i * 4)]  = 32'hA0 + 32'(i);
    end
    @(negedge clk);
    chk("rst_hit", {31'b0, hit}, 1);
    chk("rst_req", {31'b0, memReq}, 0);
    chk("rst_we", {31'b0, memWe}, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWData, 0);
`ifdef DCACHE_STATS_EN
    chk("rst_hitcount", hitCount, 0);
    chk("rst_misscount", missCount, 0);
`endif
    reset = 1'b0;
    lat_mode = 0;
    access(1, 0, 32'h100, 0);
    access(1, 0, 32'h108, 0);
    access(0, 1, 32'h104, 32'hDEADBEEF);
    access(1, 0, 32'h104, 0);
    access(0, 1, 32'h2000, 32'h0BADF00D);
    access(1, 0, 32'h2000, 0);
    access(1, 0, 32'h1100, 0);
    access(1, 0, 32'h100, 0);
    access(1, 1, 32'h108, 32'h13579BDF);
    access(1, 0, 32'h108, 0);
    access(0, 0, 32'h10C, 0);
    lat_mode = 3;
    @(posedge clk); #1;
    address = 32'h300; memRead = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midfill_hit", {31'b0, hit}, 0);
    end
    chk("midfill_req", {31'b0, memReq}, 1);
    chk("midfill_addr", memAddr, 32'h304);
    #1 reset = 1'b1; memRead = 1'b0;
    #1 chk("midfill_rst_req", {31'b0, memReq}, 0);
    chk("midfill_rst_addr", memAddr, 0);
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    e_hit = 0; e_miss = 0;
    @(negedge clk);
    reset = 1'b0;
    access(1, 0, 32'h300, 0);
    lat_mode = 0;
    access(1, 0, 32'h300, 0);
    access(1, 0, 32'h304, 0);
    access(1, 0, 32'h30C, 0);
    access(0, 1, 32'h308, 32'hCAFEF00D);
`ifdef DCACHE_STATS_EN
    chk("stats_hitcount", hitCount, 3);
    chk("stats_misscount", missCount, 1);
`endif
    lat_mode = -1;
    for (int k = 0; k < 200; k++) begin
      int op = int'($urandom_range(9, 0));
      logic [31:0] a = (32'($urandom_range(2, 0)) << 8) | (32'($urandom_range(15, 0)) << 4) |
                       (32'($urandom_range(3, 0)) << 2) | 32'($urandom_range(3, 0));
      access(op >= 1 && op <= 6 || op == 9, op >= 7, a, $urandom);
    end
`ifdef DCACHE_STATS_EN
    chk("final_hitcount", hitCount, 32'(e_hit));
    chk("final_misscount", missCount, 32'(e_miss));
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
